// File: rtl/slim_ctrl_pkg.sv
// Shared constants and encodings for the slime controller and its address generator.
package slim_ctrl_pkg;

  localparam int SPR_W    = 34;
  localparam int SPR_H    = 33;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 14;
  localparam int COORD_W  = 10;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    WALK_L = 2'd0,
    WALK_R = 2'd1,
    FROZEN = 2'd2
  } slim_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } slim_dir_e;

endpackage

// File: rtl/slim_addr_gen.sv
// Sprite box test and row-major ROM address, registered with one cycle of latency.
module slim_addr_gen
  import slim_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hcnt,
  input  logic [COORD_W-1:0] vcnt,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_box
);

  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [ADDR_W-1:0]  row_ext;
  logic [ADDR_W-1:0]  addr_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               in_box_d;
  logic               in_box_q;

  always_comb begin
    x_end    = {1'b0, spr_x} + (COORD_W+1)'(SPR_W);
    y_end    = {1'b0, spr_y} + (COORD_W+1)'(SPR_H);
    in_box_d = (hcnt >= spr_x) && ({1'b0, hcnt} < x_end) &&
               (vcnt >= spr_y) && ({1'b0, vcnt} < y_end);
    row      = vcnt - spr_y;
    col      = hcnt - spr_x;
    row_ext  = {{(ADDR_W-COORD_W){1'b0}}, row};
    addr_d   = '0;
    // row * 34 as two shifts and an add keeps this off the multipliers
    if (in_box_d) begin
      addr_d = (row_ext << 5) + (row_ext << 1) + {{(ADDR_W-COORD_W){1'b0}}, col};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      in_box_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      in_box_q <= in_box_d;
    end
  end

  assign addr   = addr_q;
  assign in_box = in_box_q;

endmodule

// File: rtl/slim_ctrl.sv
// Slime patrol/freeze FSM plus sprite address generation for the slime renderer.
module slim_ctrl
  import slim_ctrl_pkg::*;
#(
  parameter int X_MIN         = 40,
  parameter int X_MAX         = 566,
  parameter int Y_POS         = 400,
  parameter int START_X       = 300,
  parameter int STEP          = 2,
  parameter int FREEZE_FRAMES = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hcnt,
  input  logic [COORD_W-1:0] vcnt,
  input  logic               frame_tick,
  input  logic               freeze_hit,
  output logic [ADDR_W-1:0]  slim,
  output logic               slim_in,
  output logic               slim_dir,
  output logic               slim_frozen,
  output logic [COORD_W-1:0] slim_x
);

  slim_state_e         state_q, state_d;
  slim_state_e         saved_q, saved_d;
  logic [COORD_W-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic                frozen_q, frozen_d;
  logic signed [COORD_W:0] x_left;
  logic signed [COORD_W:0] x_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WALK_L;
      saved_q  <= WALK_L;
      pos_q    <= COORD_W'(START_X);
      cnt_q    <= '0;
      dir_q    <= DIR_LEFT;
      frozen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      frozen_q <= frozen_d;
    end
  end

  // A hit always takes priority over movement, and movement only happens on frame_tick
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    x_left  = signed'({1'b0, pos_q}) - signed'((COORD_W+1)'(STEP));
    x_right = signed'({1'b0, pos_q}) + signed'((COORD_W+1)'(STEP));
    case (state_q)
      WALK_L: begin
        if (freeze_hit) begin
          state_d = FROZEN;
          saved_d = WALK_L;
          cnt_d   = CNT_W'(FREEZE_FRAMES);
        end else if (frame_tick) begin
          if (x_left <= signed'((COORD_W+1)'(X_MIN))) begin
            pos_d   = COORD_W'(X_MIN);
            state_d = WALK_R;
          end else begin
            pos_d = x_left[COORD_W-1:0];
          end
        end
      end
      WALK_R: begin
        if (freeze_hit) begin
          state_d = FROZEN;
          saved_d = WALK_R;
          cnt_d   = CNT_W'(FREEZE_FRAMES);
        end else if (frame_tick) begin
          if (x_right >= signed'((COORD_W+1)'(X_MAX))) begin
            pos_d   = COORD_W'(X_MAX);
            state_d = WALK_L;
          end else begin
            pos_d = x_right[COORD_W-1:0];
          end
        end
      end
      FROZEN: begin
        if (freeze_hit) begin
          cnt_d = CNT_W'(FREEZE_FRAMES);
        end else if (frame_tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = saved_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = WALK_L;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops alongside it
  always_comb begin
    frozen_d = (state_d == FROZEN);
    dir_d    = (state_d == WALK_R) || ((state_d == FROZEN) && (saved_d == WALK_R));
  end

  slim_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .spr_x  (pos_q),
    .spr_y  (COORD_W'(Y_POS)),
    .addr   (slim),
    .in_box (slim_in)
  );

  assign slim_x      = pos_q;
  assign slim_dir    = dir_q;
  assign slim_frozen = frozen_q;

endmodule

// File: tb/tb_slim_ctrl.sv
// Directed self-checking bench for slim_ctrl: patrol, clamping, freeze timing, address path, async reset.
module tb_slim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcnt, vcnt;
  logic        a_tick, a_hit, b_tick, b_hit;
  logic [13:0] a_slim, b_slim;
  logic        a_in, a_dir, a_frozen, b_in, b_dir, b_frozen;
  logic [9:0]  a_x, b_x;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  slim_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt),
    .frame_tick(a_tick), .freeze_hit(a_hit),
    .slim(a_slim), .slim_in(a_in), .slim_dir(a_dir),
    .slim_frozen(a_frozen), .slim_x(a_x)
  );

  slim_ctrl #(.START_X(44)) dut_b (
    .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt),
    .frame_tick(b_tick), .freeze_hit(b_hit),
    .slim(b_slim), .slim_in(b_in), .slim_dir(b_dir),
    .slim_frozen(b_frozen), .slim_x(b_x)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic hit);
    a_tick = tick;
    a_hit  = hit;
    @(posedge clk);
    #1;
    a_tick = 1'b0;
    a_hit  = 1'b0;
  endtask

  task automatic tickB();
    b_tick = 1'b1;
    @(posedge clk);
    #1;
    b_tick = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    hcnt   = '0;
    vcnt   = '0;
    a_tick = 1'b0;
    a_hit  = 1'b0;
    b_tick = 1'b0;
    b_hit  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    checkOutput("reset_x", a_x, 300);
    checkOutput("reset_dir", a_dir, 0);
    checkOutput("reset_frozen", a_frozen, 0);
    checkOutput("reset_slim", a_slim, 0);
    checkOutput("reset_in", a_in, 0);
    checkOutput("reset_b_x", b_x, 44);

    // address path with sprite at x=300, y=400
    hcnt = 10'd300; vcnt = 10'd400; applyStimulus(0, 0);
    checkOutput("addr_origin", a_slim, 0);
    checkOutput("addr_origin_in", a_in, 1);
    hcnt = 10'd333; vcnt = 10'd432; applyStimulus(0, 0);
    checkOutput("addr_corner", a_slim, 1121);
    checkOutput("addr_corner_in", a_in, 1);
    hcnt = 10'd310; vcnt = 10'd405; applyStimulus(0, 0);
    checkOutput("addr_mid", a_slim, 180);
    hcnt = 10'd334; vcnt = 10'd400; applyStimulus(0, 0);
    checkOutput("addr_right_out", a_in, 0);
    checkOutput("addr_right_slim", a_slim, 0);
    hcnt = 10'd299; vcnt = 10'd410; applyStimulus(0, 0);
    checkOutput("addr_left_out", a_in, 0);
    hcnt = 10'd310; vcnt = 10'd433; applyStimulus(0, 0);
    checkOutput("addr_below_out", a_in, 0);
    checkOutput("no_tick_hold", a_x, 300);

    // left clamp then right clamp on the START_X=44 instance
    tickB();
    checkOutput("b_tick1_x", b_x, 42);
    checkOutput("b_tick1_dir", b_dir, 0);
    tickB();
    checkOutput("b_tick2_x", b_x, 40);
    checkOutput("b_tick2_dir", b_dir, 1);
    tickB();
    checkOutput("b_tick3_x", b_x, 42);
    repeat (261) tickB();
    checkOutput("b_pre_max_x", b_x, 564);
    checkOutput("b_pre_max_dir", b_dir, 1);
    tickB();
    checkOutput("b_max_x", b_x, 566);
    checkOutput("b_max_dir", b_dir, 0);
    tickB();
    checkOutput("b_after_max_x", b_x, 564);

    // plain patrol
    repeat (10) applyStimulus(1, 0);
    checkOutput("walk10_x", a_x, 280);
    checkOutput("walk10_dir", a_dir, 0);
    checkOutput("walk10_frozen", a_frozen, 0);
    repeat (120) applyStimulus(1, 0);
    checkOutput("a_min_x", a_x, 40);
    checkOutput("a_min_dir", a_dir, 1);
    repeat (30) applyStimulus(1, 0);
    checkOutput("a_at_100", a_x, 100);

    // single freeze while walking right
    applyStimulus(0, 1);
    checkOutput("frz_frozen", a_frozen, 1);
    checkOutput("frz_dir", a_dir, 1);
    repeat (179) applyStimulus(1, 0);
    checkOutput("frz179_x", a_x, 100);
    checkOutput("frz179_frozen", a_frozen, 1);
    applyStimulus(1, 0);
    checkOutput("frz180_frozen", a_frozen, 0);
    checkOutput("frz180_dir", a_dir, 1);
    checkOutput("frz180_x", a_x, 100);
    applyStimulus(1, 0);
    checkOutput("frz181_x", a_x, 102);

    // hit coincident with tick, then a reload after 50 ticks
    repeat (49) applyStimulus(1, 0);
    checkOutput("a_at_200", a_x, 200);
    applyStimulus(1, 1);
    checkOutput("coin_x", a_x, 200);
    checkOutput("coin_frozen", a_frozen, 1);
    repeat (50) applyStimulus(1, 0);
    applyStimulus(1, 1);
    repeat (179) applyStimulus(1, 0);
    checkOutput("reload229_frozen", a_frozen, 1);
    checkOutput("reload229_x", a_x, 200);
    applyStimulus(1, 0);
    checkOutput("reload230_frozen", a_frozen, 0);
    checkOutput("reload230_dir", a_dir, 1);
    checkOutput("reload230_x", a_x, 200);

    // freeze again, then pull reset mid-freeze between clock edges
    applyStimulus(0, 1);
    hcnt = 10'd210; vcnt = 10'd410;
    repeat (90) applyStimulus(1, 0);
    checkOutput("pre_rst_frozen", a_frozen, 1);
    checkOutput("pre_rst_in", a_in, 1);
    checkOutput("pre_rst_slim", a_slim, 350);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_x", a_x, 300);
    checkOutput("arst_frozen", a_frozen, 0);
    checkOutput("arst_dir", a_dir, 0);
    checkOutput("arst_slim", a_slim, 0);
    checkOutput("arst_in", a_in, 0);
    checkOutput("arst_b_x", b_x, 44);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0);
    checkOutput("post_rst_first_tick", a_x, 298);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
